// File: rtl/micro_ctrl_seq.sv
// rtl/micro_ctrl_seq.sv - four-phase micro-instruction sequencer with micro-PC
//
// Walks each accepted micro-instruction through DECODE -> EXECUTE1 -> EXECUTE2,
// gating the decoded register-file/ALU enables and advancing the micro-PC.
//
// Ports:
//   sys_clk           rising-edge clock
//   sys_reset         asynchronous active-low reset
//   run               allow sequencing; low parks in IDLE at instruction boundary
//   minst_valid/ready micro-instruction handshake (ready only in DECODE with run)
//   is_branch_md, branch_target_md, reg_file_en_md, reg_file_rw_md, alu_en_md
//                     decoded fields, captured on the handshake cycle
//   branch_cond       ALU branch condition, used only in EXECUTE2
//   stall             holds the sequencer in EXECUTE1
//   control_state     current phase encoding
//   reg_file_en, reg_file_rw, alu_en  sequenced enables (EXECUTE1/EXECUTE2 only)
//   upc               micro-program counter
//   retire            high while in EXECUTE2
module micro_ctrl_seq #(
  parameter int                           BRANCH_ADDR_WIDTH = 10,
  parameter logic [BRANCH_ADDR_WIDTH-1:0] UPC_RESET         = '0,
  parameter logic [1:0]                   DECODE            = 2'd0,
  parameter logic [1:0]                   EXECUTE1          = 2'd1,
  parameter logic [1:0]                   EXECUTE2          = 2'd2,
  parameter logic [1:0]                   IDLE              = 2'd3
) (
  input  logic                         sys_clk,
  input  logic                         sys_reset,
  input  logic                         run,
  input  logic                         minst_valid,
  output logic                         minst_ready,
  input  logic                         is_branch_md,
  input  logic [BRANCH_ADDR_WIDTH-1:0] branch_target_md,
  input  logic                         branch_cond,
  input  logic                         reg_file_en_md,
  input  logic                         reg_file_rw_md,
  input  logic                         alu_en_md,
  input  logic                         stall,
  output logic [1:0]                   control_state,
  output logic                         reg_file_en,
  output logic                         reg_file_rw,
  output logic                         alu_en,
  output logic [BRANCH_ADDR_WIDTH-1:0] upc,
  output logic                         retire
);

  logic [1:0]                   state_q, state_d;
  logic [BRANCH_ADDR_WIDTH-1:0] upc_q, upc_d;
  logic                         is_branch_q, is_branch_d;
  logic [BRANCH_ADDR_WIDTH-1:0] target_q, target_d;
  logic                         rf_en_q, rf_en_d;
  logic                         rf_rw_q, rf_rw_d;
  logic                         alu_en_q, alu_en_d;

  logic handshake;
  logic executing;

  assign minst_ready = (state_q == DECODE) && run;
  assign handshake   = minst_valid && minst_ready;
  assign executing   = (state_q == EXECUTE1) || (state_q == EXECUTE2);

  always_comb begin
    state_d     = state_q;
    upc_d       = upc_q;
    is_branch_d = is_branch_q;
    target_d    = target_q;
    rf_en_d     = rf_en_q;
    rf_rw_d     = rf_rw_q;
    alu_en_d    = alu_en_q;
    case (state_q)
      IDLE: begin
        if (run) state_d = DECODE;
      end
      DECODE: begin
        if (handshake) begin
          is_branch_d = is_branch_md;
          target_d    = branch_target_md;
          rf_en_d     = reg_file_en_md;
          rf_rw_d     = reg_file_rw_md;
          alu_en_d    = alu_en_md;
          state_d     = EXECUTE1;
        end else if (!run) begin
          state_d = IDLE;
        end
      end
      EXECUTE1: begin
        if (!stall) state_d = EXECUTE2;
      end
      default: begin
        // EXECUTE2: the instruction always completes, run only picks what follows.
        if (is_branch_q && branch_cond) upc_d = target_q;
        else                            upc_d = upc_q + 1'b1;
        state_d = run ? DECODE : IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      state_q     <= IDLE;
      upc_q       <= UPC_RESET;
      is_branch_q <= 1'b0;
      target_q    <= '0;
      rf_en_q     <= 1'b0;
      rf_rw_q     <= 1'b0;
      alu_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      upc_q       <= upc_d;
      is_branch_q <= is_branch_d;
      target_q    <= target_d;
      rf_en_q     <= rf_en_d;
      rf_rw_q     <= rf_rw_d;
      alu_en_q    <= alu_en_d;
    end
  end

  assign control_state = state_q;
  assign upc           = upc_q;
  assign retire        = (state_q == EXECUTE2);
  // Enables are decoded from state so reset clears them in the same cycle.
  assign reg_file_en   = executing && rf_en_q;
  assign reg_file_rw   = executing && rf_rw_q;
  assign alu_en        = executing && alu_en_q;

endmodule

// File: tb/tb_micro_ctrl_seq.sv
// tb/tb_micro_ctrl_seq.sv - directed vector bench for micro_ctrl_seq
module tb_micro_ctrl_seq;

  logic       sys_clk = 1'b0;
  logic       sys_reset;
  logic       run, minst_valid, minst_ready;
  logic       is_branch_md, branch_cond, reg_file_en_md, reg_file_rw_md, alu_en_md, stall;
  logic [9:0] branch_target_md;
  logic [1:0] control_state;
  logic       reg_file_en, reg_file_rw, alu_en, retire;
  logic [9:0] upc;

  int errors = 0;
  int checks = 0;
  int retire_cnt = 0;

  always #5 sys_clk = ~sys_clk;

  micro_ctrl_seq dut (
    .sys_clk          (sys_clk),
    .sys_reset        (sys_reset),
    .run              (run),
    .minst_valid      (minst_valid),
    .minst_ready      (minst_ready),
    .is_branch_md     (is_branch_md),
    .branch_target_md (branch_target_md),
    .branch_cond      (branch_cond),
    .reg_file_en_md   (reg_file_en_md),
    .reg_file_rw_md   (reg_file_rw_md),
    .alu_en_md        (alu_en_md),
    .stall            (stall),
    .control_state    (control_state),
    .reg_file_en      (reg_file_en),
    .reg_file_rw      (reg_file_rw),
    .alu_en           (alu_en),
    .upc              (upc),
    .retire           (retire)
  );

  always @(negedge sys_clk) if (retire) retire_cnt++;

  typedef struct {
    logic       run, valid, br;
    logic [9:0] tgt;
    logic       en, rw, alu, stl, cond;
    logic [1:0] st;
    logic       rdy, o_en, o_rw, o_alu, ret;
    logic [9:0] o_upc;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(logic r, logic v, logic b, logic [9:0] t, logic e, logic w,
                              logic a, logic s, logic c, logic [1:0] xs, logic xr,
                              logic xe, logic xw, logic xa, logic xt, logic [9:0] xu);
    vec_t x;
    x.run = r; x.valid = v; x.br = b; x.tgt = t; x.en = e; x.rw = w; x.alu = a;
    x.stl = s; x.cond = c; x.st = xs; x.rdy = xr; x.o_en = xe; x.o_rw = xw;
    x.o_alu = xa; x.ret = xt; x.o_upc = xu;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic v, input logic b, input logic [9:0] t,
                       input logic e, input logic w, input logic a, input logic s,
                       input logic c);
    run = r; minst_valid = v; is_branch_md = b; branch_target_md = t;
    reg_file_en_md = e; reg_file_rw_md = w; alu_en_md = a; stall = s; branch_cond = c;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int rc0;
    //           run v br tgt    en rw al st cd   st rdy en rw al ret upc
    tbl[0]  = mk(1, 1, 0, 10'h000, 1, 1, 0, 0, 0, 3, 0, 0, 0, 0, 0, 10'h000);
    tbl[1]  = mk(1, 1, 0, 10'h000, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 10'h000);
    tbl[2]  = mk(1, 0, 0, 10'h000, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 10'h000);
    tbl[3]  = mk(1, 0, 0, 10'h000, 0, 0, 0, 0, 0, 2, 0, 1, 1, 0, 1, 10'h000);
    tbl[4]  = mk(1, 0, 0, 10'h000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 10'h001);
    tbl[5]  = mk(1, 1, 1, 10'h3A5, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 10'h001);
    tbl[6]  = mk(1, 0, 0, 10'h111, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 10'h001);
    tbl[7]  = mk(1, 0, 0, 10'h111, 0, 0, 0, 0, 1, 2, 0, 0, 0, 1, 1, 10'h001);
    tbl[8]  = mk(1, 1, 1, 10'h3A5, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 10'h3A5);
    tbl[9]  = mk(1, 0, 0, 10'h000, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 10'h3A5);
    tbl[10] = mk(1, 0, 0, 10'h000, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 1, 10'h3A5);
    tbl[11] = mk(1, 1, 0, 10'h000, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 10'h3A6);
    tbl[12] = mk(1, 0, 0, 10'h000, 0, 0, 0, 0, 1, 1, 0, 1, 0, 1, 0, 10'h3A6);
    tbl[13] = mk(0, 0, 0, 10'h000, 0, 0, 0, 0, 1, 2, 0, 1, 0, 1, 1, 10'h3A6);
    tbl[14] = mk(0, 0, 0, 10'h000, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 10'h3A7);
    tbl[15] = mk(1, 0, 0, 10'h000, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 10'h3A7);
    tbl[16] = mk(0, 1, 1, 10'h2AA, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 10'h3A7);
    tbl[17] = mk(0, 0, 0, 10'h000, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 10'h3A7);

    sys_reset = 1'b0;
    drive(1, 1, 0, 10'h000, 1, 1, 1, 0, 1);
    repeat (2) @(negedge sys_clk);
    chk("rst_state", control_state, 2'd3);
    chk("rst_upc", upc, 10'h000);
    chk("rst_ready", minst_ready, 1'b0);
    chk("rst_enables", {reg_file_en, reg_file_rw, alu_en}, 3'b000);
    chk("rst_retire", retire, 1'b0);
    @(posedge sys_clk);
    #1 sys_reset = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].run, tbl[i].valid, tbl[i].br, tbl[i].tgt, tbl[i].en, tbl[i].rw,
            tbl[i].alu, tbl[i].stl, tbl[i].cond);
      @(negedge sys_clk);
      chk($sformatf("v%0d_state", i), control_state, tbl[i].st);
      chk($sformatf("v%0d_ready", i), minst_ready, tbl[i].rdy);
      chk($sformatf("v%0d_rf_en", i), reg_file_en, tbl[i].o_en);
      chk($sformatf("v%0d_rf_rw", i), reg_file_rw, tbl[i].o_rw);
      chk($sformatf("v%0d_alu_en", i), alu_en, tbl[i].o_alu);
      chk($sformatf("v%0d_retire", i), retire, tbl[i].ret);
      chk($sformatf("v%0d_upc", i), upc, tbl[i].o_upc);
      @(posedge sys_clk);
      #1;
    end

    // upc wrap: branch to 0x3FF, then a sequential retire rolls over to 0.
    drive(1, 0, 0, 10'h000, 0, 0, 0, 0, 0);
    cyc();
    drive(1, 1, 1, 10'h3FF, 0, 0, 0, 0, 0);
    cyc();
    drive(1, 0, 0, 10'h000, 0, 0, 0, 0, 1);
    cyc();
    cyc();
    chk("wrap_pre_upc", upc, 10'h3FF);
    drive(1, 1, 0, 10'h155, 0, 0, 0, 0, 1);
    cyc();
    drive(1, 0, 0, 10'h000, 0, 0, 0, 0, 1);
    cyc();
    cyc();
    chk("wrap_upc", upc, 10'h000);
    chk("wrap_state", control_state, 2'd0);

    // stall held three cycles: EXECUTE1 occupies four cycles, enables stable.
    rc0 = retire_cnt;
    drive(1, 1, 0, 10'h000, 1, 1, 1, 1, 0);
    cyc();
    drive(1, 0, 0, 10'h000, 0, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall%0d_state", k), control_state, 2'd1);
      chk($sformatf("stall%0d_en", k), {reg_file_en, reg_file_rw, alu_en}, 3'b111);
      cyc();
    end
    chk("stall3_state", control_state, 2'd1);
    chk("stall3_en", {reg_file_en, reg_file_rw, alu_en}, 3'b111);
    stall = 1'b0;
    cyc();
    chk("stall_e2_state", control_state, 2'd2);
    chk("stall_e2_retire", retire, 1'b1);
    cyc();
    chk("stall_done_state", control_state, 2'd0);
    chk("stall_retire_count", retire_cnt - rc0, 1);
    chk("stall_upc", upc, 10'h001);

    // run dropped in EXECUTE1: instruction still retires, then IDLE.
    drive(1, 1, 0, 10'h000, 1, 0, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 10'h000, 0, 0, 0, 0, 0);
    chk("rundrop_e1", control_state, 2'd1);
    cyc();
    chk("rundrop_e2_retire", retire, 1'b1);
    chk("rundrop_e2_ready", minst_ready, 1'b0);
    cyc();
    chk("rundrop_idle", control_state, 2'd3);
    chk("rundrop_ready", minst_ready, 1'b0);
    chk("rundrop_upc", upc, 10'h002);
    cyc();
    chk("rundrop_stay_idle", control_state, 2'd3);

    // asynchronous reset in EXECUTE1: immediate IDLE, no retire, upc cleared.
    drive(1, 0, 0, 10'h000, 0, 0, 0, 0, 0);
    cyc();
    drive(1, 1, 0, 10'h000, 1, 1, 1, 0, 0);
    cyc();
    drive(1, 0, 0, 10'h000, 0, 0, 0, 0, 0);
    chk("rst_mid_pre_state", control_state, 2'd1);
    rc0 = retire_cnt;
    #1 sys_reset = 1'b0;
    #1;
    chk("rst_mid_state", control_state, 2'd3);
    chk("rst_mid_en", {reg_file_en, reg_file_rw, alu_en}, 3'b000);
    chk("rst_mid_retire", retire, 1'b0);
    chk("rst_mid_upc", upc, 10'h000);
    cyc();
    cyc();
    chk("rst_mid_no_retire", retire_cnt - rc0, 0);
    sys_reset = 1'b1;
    chk("rst_rel_state", control_state, 2'd3);
    cyc();
    chk("rst_rel_decode", control_state, 2'd0);
    chk("rst_rel_upc", upc, 10'h000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/micro_ctrl_seq.md
MICRO_CTRL_SEQ -- requirements
Module: micro_ctrl_seq

Interface
REQ-001 SHALL have parameter BRANCH_ADDR_WIDTH, default 10, micro-PC and branch target width.
REQ-002 SHALL have parameter UPC_RESET, default 0, micro-PC value after reset.
REQ-003 SHALL have parameter DECODE, default 0, control_state encoding for decode.
REQ-004 SHALL have parameter EXECUTE1, default 1, control_state encoding for execute phase 1.
REQ-005 SHALL have parameter EXECUTE2, default 2, control_state encoding for execute phase 2.
REQ-006 SHALL have parameter IDLE, default 3, control_state encoding for idle.
REQ-007 SHALL have port sys_clk  input  1  single clock; all state updates on its rising edge.
REQ-008 SHALL have port sys_reset  input  1  asynchronous, active-low reset.
REQ-009 SHALL have port run  input  1  enables sequencing; low parks the FSM in IDLE at an instruction boundary.
REQ-010 SHALL have port minst_valid  input  1  decoder holds a valid micro-instruction.
REQ-011 SHALL have port minst_ready  output  1  sequencer accepts a micro-instruction this cycle.
REQ-012 SHALL have port is_branch_md  input  1  decoded instruction is a branch.
REQ-013 SHALL have port branch_target_md  input  BRANCH_ADDR_WIDTH  decoded branch target.
REQ-014 SHALL have port branch_cond  input  1  branch condition from ALU, sampled in EXECUTE2.
REQ-015 SHALL have ports reg_file_en_md, reg_file_rw_md, alu_en_md  input  1 each  decoded enables.
REQ-016 SHALL have port stall  input  1  holds the FSM in EXECUTE1.
REQ-017 SHALL have port control_state  output  2  current phase, drives register file and ALU.
REQ-018 SHALL have ports reg_file_en, reg_file_rw, alu_en  output  1 each  sequenced enables.
REQ-019 SHALL have port upc  output  BRANCH_ADDR_WIDTH  micro-program counter.
REQ-020 SHALL have port retire  output  1  one-cycle pulse on instruction completion.

Function
REQ-021 FSM SHALL have states IDLE, DECODE, EXECUTE1, EXECUTE2; control_state SHALL equal the current state encoding.
REQ-022 IDLE: run=1 -> DECODE next cycle; else stay.
REQ-023 minst_ready SHALL be 1 only when state==DECODE and run==1 (combinational).
REQ-024 DECODE: minst_valid&&minst_ready -> capture is_branch_md, branch_target_md, reg_file_en_md, reg_file_rw_md, alu_en_md, then EXECUTE1; run=0 -> IDLE; else stay.
REQ-025 Decoded inputs SHALL be sampled only on the handshake cycle; minst_valid without ready is ignored.
REQ-026 EXECUTE1: stall=1 -> stay in EXECUTE1 with outputs unchanged; else -> EXECUTE2.
REQ-027 EXECUTE2: unconditional; next state DECODE if run=1, else IDLE.
REQ-028 reg_file_en, reg_file_rw, alu_en SHALL drive the captured values in EXECUTE1 and EXECUTE2, and 0 in IDLE and DECODE.
REQ-029 retire SHALL be 1 exactly while state==EXECUTE2.
REQ-030 At the EXECUTE2 clock edge upc SHALL load branch target if captured is_branch && branch_cond, else upc+1 modulo 2^BRANCH_ADDR_WIDTH.
REQ-031 branch_cond SHALL be ignored for non-branch instructions and in all other states.
REQ-032 Latency: handshake in cycle N -> EXECUTE1 at N+1 -> EXECUTE2/retire at N+2 -> DECODE at N+3 (no stall); stall adds one cycle per stalled cycle.
REQ-033 run deasserted during EXECUTE1/EXECUTE2 SHALL NOT abort the instruction; FSM enters IDLE after EXECUTE2.
REQ-034 upc SHALL change only at the EXECUTE2 edge or on reset.

Reset
REQ-035 sys_reset low SHALL immediately force state IDLE (control_state=3), upc=UPC_RESET, reg_file_en=reg_file_rw=alu_en=0, retire=0, minst_ready=0, captured fields=0.
REQ-036 Reset asserted mid-instruction SHALL discard it with no retire pulse; reset release SHALL begin from IDLE.

Verification
REQ-037 Reset release, run=1, minst_valid=1 non-branch rw=1 en=1 -> control_state 3,0,1,2,0; reg_file_en=1 in states 1,2; retire once; upc 0->1.
REQ-038 Branch target 0x3A5, branch_cond=1 in EXECUTE2 -> upc=0x3A5; repeat with branch_cond=0 -> upc=0x3A6.
REQ-039 upc=0x3FF, non-branch retire -> upc=0x000.
REQ-040 stall=1 for 3 cycles in EXECUTE1 -> EXECUTE1 held 4 cycles total, enables stable, single retire.
REQ-041 run dropped in EXECUTE1 -> instruction retires, FSM goes to IDLE, minst_ready stays 0.
REQ-042 sys_reset asserted in EXECUTE1 -> control_state=3 and enables=0 same cycle, no retire, upc=0.
